// File: rtl/ntt_stream_ctrl.sv
// Batch stream controller for an NTT core: waits a fixed preload delay, streams
// polynomial words from memory into the core, then writes results back (optionally bit-reversed).
module ntt_stream_ctrl #(
  parameter  int LOGN      = 10,
  parameter  int LOGQ      = 64,
  parameter  int LOGL      = 1,
  parameter  int BATCH_W   = 3,
  parameter  int RD_LAT    = 2,
  parameter  int START_DLY = 10,
  localparam int WL        = LOGN - LOGL,
  localparam int AW        = WL + BATCH_W,
  localparam int DW        = (2 ** LOGL) * LOGQ
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               intt,
  input  logic               btf_gs,
  input  logic [BATCH_W-1:0] npoly,
  input  logic               bitrev_wr,
  output logic               rd_en,
  output logic [AW-1:0]      rd_addr,
  input  logic [DW-1:0]      rd_data,
  output logic               core_start,
  output logic               core_intt,
  output logic               core_btf_gs,
  output logic               core_in_valid,
  output logic [DW-1:0]      core_din,
  input  logic               core_out_valid,
  input  logic [DW-1:0]      core_dout,
  output logic               wea,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int DLY_W = (START_DLY > 1) ? $clog2(START_DLY) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_STREAM, S_DRAIN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   dly_q, dly_d;
  logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
  logic [AW-1:0]      wr_cnt_q, wr_cnt_d;
  logic               wr_done_q, wr_done_d;
  logic [RD_LAT-1:0]  rd_pipe_q, rd_pipe_d;
  logic [BATCH_W-1:0] npoly_q, npoly_d;
  logic               intt_q, intt_d, btf_q, btf_d, bitrev_q, bitrev_d;
  logic               err_q, err_d;
  logic               start_acc, streaming, wr_acc;
  logic [AW-1:0]      last_addr;

  function automatic logic [WL-1:0] bit_reverse(input logic [WL-1:0] v);
    logic [WL-1:0] r;
    for (int k = 0; k < WL; k++) r[k] = v[WL-1-k];
    return r;
  endfunction

  assign start_acc = (state_q == S_IDLE) && start;
  assign streaming = (state_q == S_STREAM) || (state_q == S_DRAIN);
  // Writes beyond the batch or outside the streaming window are refused and flagged.
  assign wr_acc    = core_out_valid && streaming && !wr_done_q;
  assign last_addr = {npoly_q - BATCH_W'(1), {WL{1'b1}}};

  // NOTE: clocked blocks use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_PRELOAD;
      S_PRELOAD: if (dly_q == DLY_W'(START_DLY - 1)) state_d = S_STREAM;
      S_STREAM:  if (rd_cnt_q == last_addr) state_d = wr_done_d ? S_DONE : S_DRAIN;
      S_DRAIN:   if (wr_done_d) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_en      = (state_q == S_STREAM);
    core_start = streaming;
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

  assign rd_addr       = rd_cnt_q;
  assign core_in_valid = rd_pipe_q[RD_LAT-1];
  assign core_din      = rd_data;
  assign core_intt     = intt_q;
  assign core_btf_gs   = btf_q;
  assign wea           = wr_acc;
  assign wr_addr       = bitrev_q ? {wr_cnt_q[AW-1:WL], bit_reverse(wr_cnt_q[WL-1:0])} : wr_cnt_q;
  assign wr_data       = core_dout;
  assign err           = err_q;

  // NOTE: every _d gets its hold value first, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    dly_d     = dly_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_done_d = wr_done_q;
    npoly_d   = npoly_q;
    intt_d    = intt_q;
    btf_d     = btf_q;
    bitrev_d  = bitrev_q;
    err_d     = err_q;
    rd_pipe_d[0] = rd_en;
    for (int k = 1; k < RD_LAT; k++) rd_pipe_d[k] = rd_pipe_q[k-1];

    if (start_acc) begin
      dly_d     = '0;
      rd_cnt_d  = '0;
      wr_cnt_d  = '0;
      wr_done_d = 1'b0;
      npoly_d   = (npoly == '0) ? BATCH_W'(1) : npoly;
      intt_d    = intt;
      btf_d     = btf_gs;
      bitrev_d  = bitrev_wr;
      err_d     = 1'b0;
    end
    if (state_q == S_PRELOAD) dly_d = dly_q + DLY_W'(1);
    // Both address counters wrap to zero on their last word so they never leave {P-1, W-1}.
    if (rd_en) rd_cnt_d = (rd_cnt_q == last_addr) ? '0 : rd_cnt_q + AW'(1);
    if (wr_acc) begin
      if (wr_cnt_q == last_addr) begin
        wr_cnt_d  = '0;
        wr_done_d = 1'b1;
      end else begin
        wr_cnt_d  = wr_cnt_q + AW'(1);
      end
    end
    if (core_out_valid && !wr_acc) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dly_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      wr_done_q <= 1'b0;
      rd_pipe_q <= '0;
      npoly_q   <= '0;
      intt_q    <= 1'b0;
      btf_q     <= 1'b0;
      bitrev_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      dly_q     <= dly_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_done_q <= wr_done_d;
      rd_pipe_q <= rd_pipe_d;
      npoly_q   <= npoly_d;
      intt_q    <= intt_d;
      btf_q     <= btf_d;
      bitrev_q  <= bitrev_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ntt_stream_ctrl.sv
// Scoreboard bench for ntt_stream_ctrl: a memory model and a fixed-delay core model
// surround the DUT; expected reads/writes are queued at issue and popped by a monitor.
module tb_ntt_stream_ctrl;
  localparam int LOGN = 4, LOGQ = 16, LOGL = 1, BATCH_W = 3, RD_LAT = 2, START_DLY = 10;
  localparam int WL = LOGN - LOGL, W = 1 << WL, AW = WL + BATCH_W, DW = (1 << LOGL) * LOGQ;
  localparam int CORE_LAT = 5;
  localparam logic [DW-1:0] KEY = 32'hC3A5_0F96;

  logic               clk, rst, start, intt, btf_gs, bitrev_wr;
  logic [BATCH_W-1:0] npoly;
  logic               rd_en, core_start, core_intt, core_btf_gs, core_in_valid;
  logic [AW-1:0]      rd_addr, wr_addr;
  logic [DW-1:0]      rd_data, core_din, core_dout, wr_data;
  logic               core_out_valid, wea, busy, done, err;
  logic               extra_ov;

  int checks = 0, failures = 0, done_cnt = 0, exp_done = 0, cur_total = 0;
  int exp_rd[$];
  int exp_wa[$];
  logic [DW-1:0] exp_wd[$];

  ntt_stream_ctrl #(.LOGN(LOGN), .LOGQ(LOGQ), .LOGL(LOGL), .BATCH_W(BATCH_W),
                    .RD_LAT(RD_LAT), .START_DLY(START_DLY)) dut (
    .clk(clk), .rst(rst), .start(start), .intt(intt), .btf_gs(btf_gs), .npoly(npoly),
    .bitrev_wr(bitrev_wr), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .core_start(core_start), .core_intt(core_intt), .core_btf_gs(core_btf_gs),
    .core_in_valid(core_in_valid), .core_din(core_din), .core_out_valid(core_out_valid),
    .core_dout(core_dout), .wea(wea), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input int a);
    logic [15:0] hi, lo;
    hi = 16'(a * 257 + 3);
    lo = 16'(a) ^ 16'h5a5a;
    return {hi, lo};
  endfunction

  function automatic int rev(input int v);
    int r = 0;
    for (int b = 0; b < WL; b++) r = (r << 1) | ((v >> b) & 1);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Memory with RD_LAT read latency.
  logic [AW-1:0] apipe [RD_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < RD_LAT; k++) apipe[k] <= '0;
    else begin
      apipe[0] <= rd_addr;
      for (int k = 1; k < RD_LAT; k++) apipe[k] <= apipe[k-1];
    end
  end
  assign rd_data = mem_word(int'(apipe[RD_LAT-1]));

  // Core: pure CORE_LAT-cycle delay with a data scramble, plus an injectable stray valid.
  logic          cv [CORE_LAT];
  logic [DW-1:0] cd [CORE_LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) for (int k = 0; k < CORE_LAT; k++) begin cv[k] <= 1'b0; cd[k] <= '0; end
    else begin
      cv[0] <= core_in_valid;
      cd[0] <= core_din;
      for (int k = 1; k < CORE_LAT; k++) begin cv[k] <= cv[k-1]; cd[k] <= cd[k-1]; end
    end
  end
  assign core_out_valid = cv[CORE_LAT-1] | extra_ov;
  assign core_dout      = cd[CORE_LAT-1] ^ KEY;

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (exp_rd.size() == 0) check("rd_unexpected", 64'(rd_addr), 64'hFFFF);
        else check("rd_addr", 64'(rd_addr), 64'(exp_rd.pop_front()));
      end
      if (wea) begin
        if (exp_wa.size() == 0) check("wr_unexpected", 64'(wr_addr), 64'hFFFF);
        else begin
          check("wr_addr", 64'(wr_addr), 64'(exp_wa.pop_front()));
          check("wr_data", 64'(wr_data), 64'(exp_wd.pop_front()));
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic issue_batch(input int np, input bit br, input bit mi, input bit mb);
    int p, n;
    p = (np == 0) ? 1 : np;
    cur_total = p * W;
    for (int k = 0; k < p * W; k++) begin
      exp_rd.push_back(k);
      exp_wa.push_back((k / W) * W + (br ? rev(k % W) : (k % W)));
      exp_wd.push_back(mem_word(k) ^ KEY);
    end
    @(negedge clk);
    start = 1'b1; npoly = np[BATCH_W-1:0]; bitrev_wr = br; intt = mi; btf_gs = mb;
    @(posedge clk); #1;
    start = 1'b0; npoly = '0; bitrev_wr = 1'b0; intt = 1'b0; btf_gs = 1'b0;
    check("busy_after_start", busy, 1);
    check("err_cleared_on_start", err, 0);
    check("core_intt", core_intt, mi);
    check("core_btf_gs", core_btf_gs, mb);
    n = 0;
    while (n <= START_DLY + 5) begin
      @(negedge clk);
      if (rd_en) break;
      n++;
    end
    check("first_rd_latency", 64'(n), 64'(START_DLY));
    check("core_start_in_stream", core_start, 1);
  endtask

  task automatic finish_batch(input bit repulse, input bit extra);
    int nw = 0, c = 0;
    bit got = 0;
    exp_done++;
    if (repulse) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    while (!got && c < 3000) begin
      @(negedge clk);
      c++;
      if (wea) nw++;
      if (done) begin
        got = 1;
        if (repulse) begin
          start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
        end
      end else if (extra && wea && nw == cur_total) begin
        @(posedge clk); #1 extra_ov = 1'b1;
        @(negedge clk);
        check("extra_wea", wea, 0);
        check("extra_in_done", done, 1);
        got = done;
        @(posedge clk); #1 extra_ov = 1'b0;
        @(negedge clk);
        check("err_after_extra", err, 1);
      end
    end
    check("done_seen", 64'(got), 1);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    check("still_idle", busy, 0);
    check("reads_left", 64'(exp_rd.size()), 0);
    check("writes_left", 64'(exp_wa.size()), 0);
    check("done_count", 64'(done_cnt), 64'(exp_done));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; intt = 1'b0; btf_gs = 1'b0; npoly = '0; bitrev_wr = 1'b0;
    extra_ov = 1'b0;
    #1;
    check("rst_rd_en", rd_en, 0);       check("rst_wea", wea, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_in_valid", core_in_valid, 0);
    check("rst_busy", busy, 0);         check("rst_done", done, 0);
    check("rst_err", err, 0);           check("rst_rd_addr", 64'(rd_addr), 0);
    check("rst_wr_addr", 64'(wr_addr), 0);
    check("rst_core_intt", core_intt, 0);
    check("rst_core_btf_gs", core_btf_gs, 0);
    #21 rst = 1'b0;

    issue_batch(1, 0, 1, 0); finish_batch(0, 0);
    issue_batch(1, 1, 0, 1); finish_batch(0, 0);
    issue_batch(3, 0, 1, 1); finish_batch(0, 0);
    issue_batch(0, 0, 0, 0); finish_batch(0, 0);
    issue_batch(1, 0, 0, 0); finish_batch(1, 0);
    issue_batch(1, 0, 0, 0); finish_batch(0, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", err, 1);

    issue_batch(1, 1, 0, 0); finish_batch(0, 0);
    check("err_clear_before_idle_hit", err, 0);
    @(posedge clk); #1 extra_ov = 1'b1;
    @(posedge clk); #1 extra_ov = 1'b0;
    @(negedge clk);
    check("err_idle_valid", err, 1);
    check("wea_idle_valid", wea, 0);

    issue_batch(2, 0, 1, 0);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    #1;
    check("arst_rd_en", rd_en, 0);      check("arst_busy", busy, 0);
    check("arst_core_start", core_start, 0);
    check("arst_core_in_valid", core_in_valid, 0);
    check("arst_wea", wea, 0);          check("arst_done", done, 0);
    check("arst_rd_addr", 64'(rd_addr), 0);
    check("arst_core_intt", core_intt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_no_done", 64'(done_cnt), 64'(exp_done));
    check("arst_err", err, 0);
    issue_batch(2, 1, 0, 1); finish_batch(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
